// File: rtl/bsg_link_upstream_serializer.sv
// Purpose: slices one core word per handshake into beats_p beats across num_ch_p channels, gated by token credits.
// Latency: a word accepted at cycle t shows beat 0 at t+1 and its last beat at t+beats_p; back-to-back words have no bubble.
// Backpressure: 1-entry holding buffer; core_ready_o drops while it is full, unless it drains on a last-beat launch.
module bsg_link_upstream_serializer #(
  parameter int core_width_p  = 64,
  parameter int num_ch_p      = 2,
  parameter int ch_width_p    = 16,
  parameter int beats_p       = 2,
  parameter int credits_p     = 16,
  parameter int token_decim_p = 4,
  parameter int sent_width_p  = 7,
  localparam int cnt_width_lp  = $clog2(credits_p + 1),
  localparam int step_width_lp = (beats_p > 1) ? $clog2(beats_p) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           core_valid_i,
  input  logic [core_width_p-1:0]        core_data_i,
  output logic                           core_ready_o,
  input  logic                           io_token_i,
  output logic [num_ch_p-1:0]            io_valid_o,
  output logic [num_ch_p*ch_width_p-1:0] io_data_o,
  output logic [cnt_width_lp-1:0]        credit_cnt_o,
  output logic [sent_width_p-1:0]        sent_cnt_o,
  output logic [step_width_lp-1:0]       step_o,
  output logic                           error_o
);

  typedef enum logic {IDLE, SEND} state_e;

  localparam int beat_width_lp = num_ch_p * ch_width_p;
  localparam logic [step_width_lp-1:0] last_step_lp = step_width_lp'(beats_p - 1);

  if (core_width_p != num_ch_p * ch_width_p * beats_p) begin : g_bad_width
    $error("core_width_p must equal num_ch_p*ch_width_p*beats_p");
  end

  state_e                     state_q, state_d;
  logic [step_width_lp-1:0]   step_q, step_d;
  logic                       buf_full_q, buf_full_d;
  logic [core_width_p-1:0]    buf_q, buf_d;
  logic [core_width_p-1:0]    shift_q, shift_d;
  logic [core_width_p-1:0]    launch_word;
  logic [beat_width_lp-1:0]   io_data_q, io_data_d;
  logic [cnt_width_lp-1:0]    credit_q, credit_d;
  logic [sent_width_p-1:0]    sent_q, sent_d;
  logic                       error_q, error_d;
  logic                       launch_point, launch_from_buf, launch, accept;
  logic                       beat_load, overflow;
  logic [31:0]                credit_sum;

  // Launch decision: a new word may start when idle or on the last beat; an empty buffer lets the incoming word bypass it.
  always_comb begin
    launch_point    = (state_q == IDLE) || (step_q == last_step_lp);
    launch_from_buf = launch_point && buf_full_q && (credit_q != '0);
    launch          = launch_point && (buf_full_q || core_valid_i) && (credit_q != '0);
    core_ready_o    = !buf_full_q ||
                      ((state_q == SEND) && (step_q == last_step_lp) && launch_from_buf);
    accept          = core_valid_i && core_ready_o;
    launch_word     = buf_full_q ? buf_q : core_data_i;
  end

  // Holding buffer: drains on a launch from it, refills on any accept that is not bypassing straight to the shifter.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (launch && buf_full_q) buf_full_d = 1'b0;
    if (accept && !(launch && !buf_full_q)) begin
      buf_full_d = 1'b1;
      buf_d      = core_data_i;
    end
  end

  // FSM next state and beat shifter: LSB beat goes out first, the rest is shifted down each beat.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    shift_d   = shift_q;
    io_data_d = io_data_q;
    beat_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = SEND;
          step_d    = '0;
          io_data_d = launch_word[beat_width_lp-1:0];
          shift_d   = launch_word >> beat_width_lp;
          beat_load = 1'b1;
        end
      end
      SEND: begin
        if (step_q != last_step_lp) begin
          step_d    = step_q + step_width_lp'(1);
          io_data_d = shift_q[beat_width_lp-1:0];
          shift_d   = shift_q >> beat_width_lp;
          beat_load = 1'b1;
        end else if (launch) begin
          step_d    = '0;
          io_data_d = launch_word[beat_width_lp-1:0];
          shift_d   = launch_word >> beat_width_lp;
          beat_load = 1'b1;
        end else begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit netting with clamp, sticky overflow error, and sent count bumped when a word's last beat is driven.
  always_comb begin
    credit_sum = 32'(credit_q) + (io_token_i ? 32'(token_decim_p) : 32'd0)
                 - (launch ? 32'd1 : 32'd0);
    overflow   = credit_sum > 32'(credits_p);
    credit_d   = overflow ? cnt_width_lp'(credits_p) : credit_sum[cnt_width_lp-1:0];
    error_d    = error_q | overflow;
    sent_d     = sent_q;
    if (beat_load && (step_d == last_step_lp)) sent_d = sent_q + sent_width_p'(1);
  end

  // State registers; reset discards any word in flight or buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      shift_q    <= '0;
      io_data_q  <= '0;
      credit_q   <= cnt_width_lp'(credits_p);
      sent_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      io_data_q  <= io_data_d;
      credit_q   <= credit_d;
      sent_q     <= sent_d;
      error_q    <= error_d;
    end
  end

  assign io_valid_o   = {num_ch_p{state_q == SEND}};
  assign io_data_o    = io_data_q;
  assign credit_cnt_o = credit_q;
  assign sent_cnt_o   = sent_q;
  assign step_o       = step_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_bsg_link_upstream_serializer.sv
// Bench for bsg_link_upstream_serializer: default 2x16 instance plus a 4x8 instance sharing the same inputs.
// A queue-based model of accepted words, credits and sent count is scored every cycle in cycle_step.
// Directed scenarios and a randomized run are sequenced from one initial block.
module tb_bsg_link_upstream_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_valid = 1'b0;
  logic [63:0] core_data = '0;
  logic        io_token = 1'b0;

  logic        ready_a, error_a, ready_b, error_b;
  logic [1:0]  valid_a;
  logic [3:0]  valid_b;
  logic [31:0] data_a, data_b;
  logic [4:0]  credit_a, credit_b;
  logic [6:0]  sent_a, sent_b;
  logic [0:0]  step_a, step_b;

  always #5 clk = ~clk;

  bsg_link_upstream_serializer dut_a (
    .clk(clk), .rst(rst), .core_valid_i(core_valid), .core_data_i(core_data),
    .core_ready_o(ready_a), .io_token_i(io_token), .io_valid_o(valid_a), .io_data_o(data_a),
    .credit_cnt_o(credit_a), .sent_cnt_o(sent_a), .step_o(step_a), .error_o(error_a));

  bsg_link_upstream_serializer #(.num_ch_p(4), .ch_width_p(8)) dut_b (
    .clk(clk), .rst(rst), .core_valid_i(core_valid), .core_data_i(core_data),
    .core_ready_o(ready_b), .io_token_i(io_token), .io_valid_o(valid_b), .io_data_o(data_b),
    .credit_cnt_o(credit_b), .sent_cnt_o(sent_b), .step_o(step_b), .error_o(error_b));

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] exp_dat[$];
  int          exp_idx[$];
  int          beat_cyc[$];
  int          cred_m = 16;
  int          sent_m = 0;
  logic        err_m = 1'b0;
  logic        tok_pend = 1'b0;
  int          cyc = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and score dut_a against the model.
  task automatic cycle_step();
    int launched;
    int b;
    logic [31:0] d;
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_dat.delete(); exp_idx.delete();
      cred_m = 16; sent_m = 0; err_m = 1'b0; tok_pend = 1'b0;
    end else begin
      launched = 0;
      if (valid_a != 2'b00) begin
        beat_cyc.push_back(cyc);
        n_cmp++;
        if (exp_dat.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: io_valid_o=%b data=%h with no word outstanding", valid_a, data_a);
        end else begin
          d = exp_dat.pop_front();
          b = exp_idx.pop_front();
          if (b == 0) launched = 1;
          if (b == 1) sent_m = (sent_m + 1) % 128;
          if (valid_a !== 2'b11 || data_a !== d || step_a !== 1'(b)) begin
            n_err++;
            $display("FAIL beat: got valid=%b data=%h step=%0d, want valid=11 data=%h step=%0d",
                     valid_a, data_a, step_a, d, b);
          end
        end
      end
      cred_m = cred_m - launched + (tok_pend ? 4 : 0);
      if (cred_m > 16) begin cred_m = 16; err_m = 1'b1; end
      n_cmp++;
      if (credit_a !== 5'(cred_m) || error_a !== err_m || sent_a !== 7'(sent_m)) begin
        n_err++;
        $display("FAIL counters: got credit=%0d error=%b sent=%0d, want credit=%0d error=%b sent=%0d",
                 credit_a, error_a, sent_a, cred_m, err_m, sent_m);
      end
      tok_pend = io_token;
      if (core_valid && ready_a) begin
        exp_dat.push_back(core_data[31:0]);  exp_idx.push_back(0);
        exp_dat.push_back(core_data[63:32]); exp_idx.push_back(1);
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle_step();
    cycle_step();
    @(posedge clk); #1;
    rst = 1'b0; core_valid = 1'b0; io_token = 1'b0;
  endtask

  // Offer n words back to back, holding each until accepted; returns just after a rising edge with valid low.
  task automatic send_words(input int n, input int budget);
    int acc = 0;
    int used = 0;
    @(posedge clk); #1;
    core_valid = 1'b1; core_data = {$urandom, $urandom};
    while (acc < n && used < budget) begin
      cycle_step();
      used++;
      if (ready_a) acc++;
      @(posedge clk); #1;
      if (acc == n) core_valid = 1'b0;
      else if (ready_a || used > 0) core_data = (acc > 0 && ready_a) ? {$urandom, $urandom} : core_data;
    end
    if (acc < n) begin
      n_cmp++; n_err++;
      $display("FAIL send_words_timeout: accepted %0d of %0d words", acc, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; core_valid = 1'b0; io_token = 1'b0;
    cycle_step();
    n_cmp++;
    if (valid_a !== 2'b00 || data_a !== 32'h0 || step_a !== 1'b0 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL reset_a_io: valid=%b data=%h step=%0d ready=%b, want 00 0 0 1", valid_a, data_a, step_a, ready_a);
    end
    n_cmp++;
    if (credit_a !== 5'd16 || sent_a !== 7'd0 || error_a !== 1'b0) begin
      n_err++; $display("FAIL reset_a_cnt: credit=%0d sent=%0d error=%b, want 16 0 0", credit_a, sent_a, error_a);
    end
    n_cmp++;
    if (valid_b !== 4'h0 || data_b !== 32'h0 || credit_b !== 5'd16 || sent_b !== 7'd0 || error_b !== 1'b0) begin
      n_err++; $display("FAIL reset_b: valid=%b data=%h credit=%0d sent=%0d error=%b", valid_b, data_b, credit_b, sent_b, error_b);
    end
    cycle_step();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [63:0] w;
    w = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    core_valid = 1'b1; core_data = w;
    cycle_step();
    n_cmp++;
    if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got a=%b b=%b, want 1 1", ready_a, ready_b);
    end
    @(posedge clk); #1;
    core_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      cycle_step();
      n_cmp++;
      if (valid_a !== 2'b11 || data_a !== w[b*32 +: 32] || step_a !== 1'(b)) begin
        n_err++; $display("FAIL single_a_beat%0d: got valid=%b data=%h step=%0d, want 11 %h %0d",
                          b, valid_a, data_a, step_a, w[b*32 +: 32], b);
      end
      n_cmp++;
      if (credit_a !== 5'd15 || sent_a !== 7'(b)) begin
        n_err++; $display("FAIL single_a_cnt%0d: got credit=%0d sent=%0d, want 15 %0d", b, credit_a, sent_a, b);
      end
      n_cmp++;
      if (valid_b !== 4'hF || step_b !== 1'(b) || credit_b !== 5'd15 || sent_b !== 7'(b)) begin
        n_err++; $display("FAIL single_b_ctl%0d: got valid=%b step=%0d credit=%0d sent=%0d", b, valid_b, step_b, credit_b, sent_b);
      end
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (data_b[c*8 +: 8] !== w[b*32 + c*8 +: 8]) begin
          n_err++; $display("FAIL single_b_ch%0d_beat%0d: got %h, want %h", c, b, data_b[c*8 +: 8], w[b*32 + c*8 +: 8]);
        end
      end
    end
    cycle_step();
    n_cmp++;
    if (valid_a !== 2'b00 || data_a !== 32'h1111_2222 || valid_b !== 4'h0) begin
      n_err++; $display("FAIL single_hold: got valid_a=%b data_a=%h valid_b=%b, want 00 11112222 0", valid_a, data_a, valid_b);
    end
  endtask

  task automatic test_streaming();
    int i0;
    apply_reset();
    i0 = beat_cyc.size();
    send_words(17, 200);
    repeat (10) cycle_step();
    n_cmp++;
    if (beat_cyc.size() - i0 != 32) begin
      n_err++; $display("FAIL stream_beats: got %0d beats, want 32", beat_cyc.size() - i0);
    end else begin
      n_cmp++;
      if (beat_cyc[beat_cyc.size()-1] - beat_cyc[i0] + 1 != 32) begin
        n_err++; $display("FAIL stream_bubble: beats spanned %0d cycles, want 32", beat_cyc[beat_cyc.size()-1] - beat_cyc[i0] + 1);
      end
    end
    n_cmp++;
    if (valid_a !== 2'b00 || ready_a !== 1'b0 || credit_a !== 5'd0 || sent_a !== 7'd16) begin
      n_err++; $display("FAIL stream_stall: got valid=%b ready=%b credit=%0d sent=%0d, want 00 0 0 16", valid_a, ready_a, credit_a, sent_a);
    end
  endtask

  task automatic test_credit_return();
    int i0;
    i0 = beat_cyc.size();
    @(posedge clk); #1; io_token = 1'b1;
    cycle_step();
    @(posedge clk); #1; io_token = 1'b0;
    cycle_step();
    n_cmp++;
    if (credit_a !== 5'd4 || valid_a !== 2'b00) begin
      n_err++; $display("FAIL credit_return: got credit=%0d valid=%b, want 4 00", credit_a, valid_a);
    end
    cycle_step();
    n_cmp++;
    if (valid_a !== 2'b11 || step_a !== 1'b0) begin
      n_err++; $display("FAIL credit_relaunch: got valid=%b step=%0d, want 11 0", valid_a, step_a);
    end
    send_words(4, 100);
    repeat (12) cycle_step();
    n_cmp++;
    if (beat_cyc.size() - i0 != 8 || credit_a !== 5'd0 || sent_a !== 7'd20 || ready_a !== 1'b0) begin
      n_err++; $display("FAIL credit_restall: got beats=%0d credit=%0d sent=%0d ready=%b, want 8 0 20 0",
                        beat_cyc.size() - i0, credit_a, sent_a, ready_a);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    send_words(15, 200);
    repeat (6) cycle_step();
    n_cmp++;
    if (credit_a !== 5'd1 || valid_a !== 2'b00) begin
      n_err++; $display("FAIL simul_setup: got credit=%0d valid=%b, want 1 00", credit_a, valid_a);
    end
    @(posedge clk); #1;
    core_valid = 1'b1; core_data = {$urandom, $urandom}; io_token = 1'b1;
    cycle_step();
    @(posedge clk); #1;
    core_valid = 1'b0; io_token = 1'b0;
    cycle_step();
    n_cmp++;
    if (credit_a !== 5'd4 || error_a !== 1'b0 || valid_a !== 2'b11) begin
      n_err++; $display("FAIL simul_net: got credit=%0d error=%b valid=%b, want 4 0 11", credit_a, error_a, valid_a);
    end
    repeat (3) cycle_step();
  endtask

  task automatic test_overflow();
    apply_reset();
    send_words(2, 50);
    repeat (6) cycle_step();
    n_cmp++;
    if (credit_a !== 5'd14 || error_a !== 1'b0) begin
      n_err++; $display("FAIL ovf_setup: got credit=%0d error=%b, want 14 0", credit_a, error_a);
    end
    @(posedge clk); #1; io_token = 1'b1;
    cycle_step();
    @(posedge clk); #1; io_token = 1'b0;
    cycle_step();
    n_cmp++;
    if (credit_a !== 5'd16 || error_a !== 1'b1) begin
      n_err++; $display("FAIL ovf_clamp: got credit=%0d error=%b, want 16 1", credit_a, error_a);
    end
    repeat (5) cycle_step();
    n_cmp++;
    if (error_a !== 1'b1 || credit_a !== 5'd16) begin
      n_err++; $display("FAIL ovf_sticky: got credit=%0d error=%b, want 16 1", credit_a, error_a);
    end
  endtask

  task automatic test_reset_mid_send();
    @(posedge clk); #1;
    core_valid = 1'b1; core_data = {$urandom, $urandom};
    cycle_step();
    @(posedge clk); #1;
    core_valid = 1'b0;
    cycle_step();
    n_cmp++;
    if (valid_a !== 2'b11 || credit_a !== 5'd15) begin
      n_err++; $display("FAIL midrst_setup: got valid=%b credit=%0d, want 11 15", valid_a, credit_a);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (valid_a !== 2'b00 || data_a !== 32'h0 || step_a !== 1'b0 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL midrst_io: got valid=%b data=%h step=%0d ready=%b, want 00 0 0 1", valid_a, data_a, step_a, ready_a);
    end
    n_cmp++;
    if (credit_a !== 5'd16 || sent_a !== 7'd0 || error_a !== 1'b0) begin
      n_err++; $display("FAIL midrst_cnt: got credit=%0d sent=%0d error=%b, want 16 0 0", credit_a, sent_a, error_a);
    end
    cycle_step();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle_step();
      n_cmp++;
      if (valid_a !== 2'b00) begin
        n_err++; $display("FAIL midrst_quiet%0d: got valid=%b, want 00", i, valid_a);
      end
    end
  endtask

  task automatic test_random();
    int  i0;
    logic acc;
    apply_reset();
    i0 = beat_cyc.size();
    for (int i = 0; i < 400; i++) begin
      cycle_step();
      acc = core_valid && ready_a;
      @(posedge clk); #1;
      if (acc || !core_valid) begin
        core_valid = ($urandom_range(0, 3) != 0);
        core_data  = {$urandom, $urandom};
      end
      io_token = ($urandom_range(0, 9) == 0);
    end
    core_valid = 1'b0; io_token = 1'b0;
    repeat (4) cycle_step();
    n_cmp++;
    if (beat_cyc.size() - i0 < 50) begin
      n_err++; $display("FAIL random_activity: got %0d beats, want at least 50", beat_cyc.size() - i0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_credit_return();
    test_simultaneous();
    test_overflow();
    test_reset_mid_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
